// File: rtl/pmu_dump.sv
// rtl/pmu_dump.sv - snapshots six PMU counters and streams them as an A5-headed byte frame.
// Optional trailing XOR checksum byte enabled by defining PMU_DUMP_CKSUM_EN.
module pmu_dump (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dump_req,
  input  logic [31:0] read_count,
  input  logic [31:0] write_count,
  input  logic [31:0] read_miss,
  input  logic [31:0] write_miss,
  input  logic [31:0] read_stalled_cycles,
  input  logic [31:0] write_stalled_cycles,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        dump_done,
  output logic [7:0]  drop_count
);

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [4:0] LAST_IDX = 5'd23;

`ifdef PMU_DUMP_CKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CKSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

  state_t       r_state, w_state_nxt;
  logic [4:0]   r_idx, w_idx_nxt;
  logic [191:0] r_shadow;
  logic [7:0]   r_tx_data, w_tx_data_nxt;
  logic         r_tx_valid, w_tx_valid_nxt;
  logic         r_busy;
  logic         r_dump_done, w_dump_done_nxt;
  logic [7:0]   r_drop_count;
  logic         w_latch;
  logic         w_xfer;
  logic [4:0]   w_sel;
  logic [7:0]   w_bit_base;
  logic [7:0]   w_shadow_byte;
`ifdef PMU_DUMP_CKSUM_EN
  logic [7:0]   r_cksum, w_cksum_nxt;
`endif

  assign w_xfer = r_tx_valid && tx_ready;

  // Byte loaded into tx_data on a transfer: index 0 after the header, idx+1 while in DATA.
  assign w_sel         = (r_state == S_DATA) ? (r_idx + 5'd1) : 5'd0;
  assign w_bit_base    = {w_sel, 3'b000};
  assign w_shadow_byte = r_shadow[w_bit_base +: 8];

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_dump_done_nxt = 1'b0;
    w_latch         = 1'b0;
`ifdef PMU_DUMP_CKSUM_EN
    w_cksum_nxt     = r_cksum;
`endif
    case (r_state)
      S_IDLE: begin
        if (dump_req) begin
          w_latch        = 1'b1;
          w_state_nxt    = S_HDR;
          w_idx_nxt      = 5'd0;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = HDR_BYTE;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_state_nxt   = S_DATA;
          w_idx_nxt     = 5'd0;
          w_tx_data_nxt = w_shadow_byte;
`ifdef PMU_DUMP_CKSUM_EN
          w_cksum_nxt   = HDR_BYTE;
`endif
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
`ifdef PMU_DUMP_CKSUM_EN
            w_state_nxt     = S_CKSUM;
            w_cksum_nxt     = r_cksum ^ r_tx_data;
            w_tx_data_nxt   = r_cksum ^ r_tx_data;
`else
            w_state_nxt     = S_IDLE;
            w_tx_valid_nxt  = 1'b0;
            w_tx_data_nxt   = 8'h00;
            w_dump_done_nxt = 1'b1;
`endif
            w_idx_nxt       = 5'd0;
          end else begin
            w_idx_nxt     = r_idx + 5'd1;
            w_tx_data_nxt = w_shadow_byte;
`ifdef PMU_DUMP_CKSUM_EN
            w_cksum_nxt   = r_cksum ^ r_tx_data;
`endif
          end
        end
      end
`ifdef PMU_DUMP_CKSUM_EN
      S_CKSUM: begin
        if (w_xfer) begin
          w_state_nxt     = S_IDLE;
          w_tx_valid_nxt  = 1'b0;
          w_tx_data_nxt   = 8'h00;
          w_dump_done_nxt = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt    = S_IDLE;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 5'd0;
      r_shadow     <= '0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_dump_done  <= 1'b0;
      r_drop_count <= 8'h00;
`ifdef PMU_DUMP_CKSUM_EN
      r_cksum      <= 8'h00;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_dump_done <= w_dump_done_nxt;
`ifdef PMU_DUMP_CKSUM_EN
      r_cksum     <= w_cksum_nxt;
`endif
      if (w_latch) begin
        r_shadow <= {write_stalled_cycles, read_stalled_cycles, write_miss,
                     read_miss, write_count, read_count};
      end
      if ((r_state != S_IDLE) && dump_req && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = r_busy;
  assign dump_done  = r_dump_done;
  assign drop_count = r_drop_count;

endmodule
